// File: rtl/comparator_4bit.sv
// comparator_4bit: registered MSB-first magnitude compare, r = {valid, gt, eq, lt}
module comparator_4bit #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       r
);
    // Inverting both sign bits maps two's complement order onto unsigned order
    localparam logic [WIDTH-1:0] FLIP = {SIGNED, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] a_m, b_m;
    logic             gt, lt, found;
    logic [3:0]       r_d, r_q;
    always_comb begin
        a_m   = a ^ FLIP;
        b_m   = b ^ FLIP;
        gt    = 1'b0;
        lt    = 1'b0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && (a_m[i] != b_m[i])) begin
                found = 1'b1;
                gt    = a_m[i];
                lt    = b_m[i];
            end
        end
        r_d = {1'b1, gt, !found, lt};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= 4'b0000;
        else        r_q <= r_d;
    end
    assign r = r_q;
endmodule

// File: tb/tb_comparator_4bit.sv
// tb_comparator_4bit: directed and random checks of unsigned and signed comparator instances
module tb_comparator_4bit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = 4'b0001, b = 4'b0010;
    logic [3:0] r_u, r_s;
    int         checks = 0, failures = 0;

    comparator_4bit #(.WIDTH(4), .SIGNED(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .r(r_u));
    comparator_4bit #(.WIDTH(4), .SIGNED(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .r(r_s));

    always #5 clk = ~clk;

    logic [3:0] ua [7] = '{4'b0010, 4'b0011, 4'b1111, 4'b0110, 4'b0010, 4'b1101, 4'b1110};
    logic [3:0] ub [7] = '{4'b0001, 4'b0011, 4'b1001, 4'b0001, 4'b0010, 4'b1110, 4'b0111};
    logic [3:0] ur [7] = '{4'b1100, 4'b1010, 4'b1100, 4'b1100, 4'b1010, 4'b1001, 4'b1100};
    logic [3:0] sa [3] = '{4'b1010, 4'b1111, 4'b1110};
    logic [3:0] sb [3] = '{4'b0101, 4'b1001, 4'b0111};
    logic [3:0] sr [3] = '{4'b1001, 4'b1100, 4'b1001};
    logic [3:0] ba [4] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
    logic [3:0] bb [4] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
    logic [3:0] br [4] = '{4'b1001, 4'b1100, 4'b1010, 4'b1010};

    function automatic logic [3:0] model(input logic [3:0] x, input logic [3:0] y, input bit s);
        logic g, l;
        g = s ? ($signed(x) > $signed(y)) : (x > y);
        l = s ? ($signed(x) < $signed(y)) : (x < y);
        return {1'b1, g, !g && !l, l};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        a = x;
        b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_u", r_u, 4'b0000);
        check("async_rst_s", r_s, 4'b0000);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("async_rel_u", r_u, model(a, b, 1'b0));
        check("async_rel_s", r_s, model(a, b, 1'b1));
    endtask

    initial begin
        #1;
        check("rst_now_u", r_u, 4'b0000);
        check("rst_now_s", r_s, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_u", r_u, 4'b0000);
            check("rst_hold_s", r_s, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_u", r_u, 4'b1001);
        check("rst_release_s", r_s, 4'b1001);
        for (int i = 0; i < 7; i++) begin
            apply(ua[i], ub[i]);
            check("unsigned_basic", r_u, ur[i]);
        end
        for (int i = 0; i < 3; i++) begin
            apply(sa[i], sb[i]);
            check("signed_basic", r_s, sr[i]);
            if (i == 0) check("unsigned_same_pair", r_u, 4'b1100);
        end
        for (int i = 0; i < 4; i++) begin
            apply(ba[i], bb[i]);
            check("boundary_u", r_u, br[i]);
        end
        apply(4'b0111, 4'b1000);
        check("boundary_s", r_s, 4'b1100);
        check("boundary_s_as_u", r_u, 4'b1001);
        for (int i = 0; i < 1000; i++) begin
            if (i == 300 || i == 700) async_reset();
            apply(4'($urandom), 4'($urandom));
            check("random_u", r_u, model(a, b, 1'b0));
            check("random_s", r_s, model(a, b, 1'b1));
            check("onehot_u", {3'b000, $onehot(r_u[2:0])}, 4'b0001);
            check("onehot_s", {3'b000, $onehot(r_s[2:0])}, 4'b0001);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
